// File: rtl/scarv_soc_reset_seq.sv
// SCARV SoC reset sequencer: ordered release of NDOMAINS
// active-low resets with software re-reset and cause log.
module scarv_soc_reset_seq #(
  parameter int NDOMAINS              = 3,
  parameter int EXT_RESET_ACTIVE_HIGH = 1,
  parameter int SYNC_STAGES           = 2,
  parameter int RESET_CYCLES_BASE     = 16,
  parameter int RESET_CYCLES_GAP      = 16,
  parameter int SW_HOLD_CYCLES        = 8
) (
  input  logic                f_clk,
  input  logic                resetn,
  input  logic                f_clk_locked,
  input  logic                sys_reset,
  input  logic [NDOMAINS-1:0] sw_reset_req,
  input  logic                cause_clr,
  output logic [NDOMAINS-1:0] domain_resetn,
  output logic                seq_busy,
  output logic [3:0]          reset_cause
);

  localparam int TOTAL =
    RESET_CYCLES_BASE + NDOMAINS * RESET_CYCLES_GAP;
  localparam int CW = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] W_TOTAL = CW'(TOTAL);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_SEQ  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  function automatic logic [CW-1:0] thr(input int i);
    return CW'(RESET_CYCLES_BASE + (i + 1) * RESET_CYCLES_GAP);
  endfunction

  logic [SYNC_STAGES-1:0] r_ext_sync;
  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic                   w_ext_raw;
  logic                   w_ext;
  logic                   w_lock;
  logic                   w_hold;

  assign w_ext_raw = (EXT_RESET_ACTIVE_HIGH != 0) ?
                     sys_reset : ~sys_reset;

  // ext chain resets asserted, lock chain resets unlocked
  always_ff @(posedge f_clk or negedge resetn) begin
    if (!resetn) begin
      r_ext_sync  <= '1;
      r_lock_sync <= '0;
    end else begin
      r_ext_sync  <= {r_ext_sync[SYNC_STAGES-2:0], w_ext_raw};
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], f_clk_locked};
    end
  end

  assign w_ext  = r_ext_sync[SYNC_STAGES-1];
  assign w_lock = r_lock_sync[SYNC_STAGES-1];
  assign w_hold = w_ext | ~w_lock;

  state_t                r_state;
  state_t                w_state_nx;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nx;
  logic [NDOMAINS-1:0]   r_dom;
  logic [NDOMAINS-1:0]   w_dom_nx;
  logic                  r_busy;
  logic                  w_busy_nx;
  logic [3:0]            r_cause;
  logic [3:0]            w_cause_set;
  logic                  w_sw_any;
  logic [CW-1:0]         w_sw_r;
  logic                  w_sw_take;

  // descending scan so the lowest requested domain wins
  always_comb begin
    w_sw_any = 1'b0;
    w_sw_r   = '0;
    for (int i = NDOMAINS - 1; i >= 0; i--) begin
      if (sw_reset_req[i]) begin
        w_sw_any = 1'b1;
        w_sw_r   = thr(i) - CW'(SW_HOLD_CYCLES);
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_sw_take  = 1'b0;
    if (w_hold) begin
      w_state_nx = S_HOLD;
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        S_HOLD: begin
          w_state_nx = S_SEQ;
          w_cnt_nx   = CW'(1);
        end
        S_SEQ, S_RUN: begin
          w_sw_take = w_sw_any && (w_sw_r < r_cnt);
          if (w_sw_take) begin
            w_state_nx = S_SEQ;
            w_cnt_nx   = w_sw_r;
          end else if (r_cnt >= W_TOTAL) begin
            w_state_nx = S_RUN;
            w_cnt_nx   = W_TOTAL;
          end else begin
            w_cnt_nx   = r_cnt + CW'(1);
            w_state_nx = (w_cnt_nx == W_TOTAL) ? S_RUN : S_SEQ;
          end
        end
        default: begin
          w_state_nx = S_HOLD;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  // a domain is released only if it is past its slot both
  // now and after this edge, so loads and holds drop it at once
  always_comb begin
    w_dom_nx = '0;
    for (int i = 0; i < NDOMAINS; i++) begin
      w_dom_nx[i] = (w_state_nx != S_HOLD) &&
                    (r_cnt >= thr(i)) &&
                    (w_cnt_nx >= thr(i));
    end
  end

  assign w_busy_nx = (r_state != S_RUN) ||
                     (w_state_nx != S_RUN);

  assign w_cause_set = {
    w_sw_take,
    w_hold & (r_state != S_HOLD) & ~w_lock,
    w_hold & (r_state != S_HOLD) & w_ext,
    1'b0
  };

  always_ff @(posedge f_clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_dom   <= '0;
      r_busy  <= 1'b1;
      r_cause <= 4'b0001;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_dom   <= w_dom_nx;
      r_busy  <= w_busy_nx;
      r_cause <= (cause_clr ? 4'b0000 : r_cause) | w_cause_set;
    end
  end

  assign domain_resetn = r_dom;
  assign seq_busy      = r_busy;
  assign reset_cause   = r_cause;

endmodule

// File: tb/tb_scarv_soc_reset_seq.sv
// Bench for scarv_soc_reset_seq: per-edge expected
// domain/busy values queued ahead and compared as they occur.
module tb_scarv_soc_reset_seq;

  localparam int ND    = 3;
  localparam int BASE  = 16;
  localparam int GAP   = 16;
  localparam int SWH   = 8;
  localparam int SYNC  = 2;
  localparam int TOTAL = BASE + ND * GAP;

  logic          f_clk = 1'b0;
  logic          resetn;
  logic          f_clk_locked;
  logic          sys_reset;
  logic [ND-1:0] sw_reset_req;
  logic          cause_clr;
  logic [ND-1:0] domain_resetn;
  logic          seq_busy;
  logic [3:0]    reset_cause;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [ND-1:0] dom;
    logic          busy;
  } exp_t;

  exp_t q[$];

  scarv_soc_reset_seq #(
    .NDOMAINS(ND),
    .EXT_RESET_ACTIVE_HIGH(1),
    .SYNC_STAGES(SYNC),
    .RESET_CYCLES_BASE(BASE),
    .RESET_CYCLES_GAP(GAP),
    .SW_HOLD_CYCLES(SWH)
  ) dut (
    .f_clk(f_clk),
    .resetn(resetn),
    .f_clk_locked(f_clk_locked),
    .sys_reset(sys_reset),
    .sw_reset_req(sw_reset_req),
    .cause_clr(cause_clr),
    .domain_resetn(domain_resetn),
    .seq_busy(seq_busy),
    .reset_cause(reset_cause)
  );

  always #5 f_clk = ~f_clk;

  function automatic int thr(input int i);
    return BASE + (i + 1) * GAP;
  endfunction

  // c: sequence counter value sampled at the edge
  function automatic exp_t mk(input int c);
    exp_t e;
    for (int i = 0; i < ND; i++) e.dom[i] = (c >= thr(i));
    e.busy = (c < TOTAL);
    return e;
  endfunction

  // hold event lasting l cycles on edge 1, counter c0 before it
  function automatic void push_seq(input int c0, input int l,
                                   input int n_edges);
    int c;
    for (int n = 1; n <= n_edges; n++) begin
      if (n <= SYNC) c = (c0 + n - 1 > TOTAL) ? TOTAL : c0 + n - 1;
      else           c = n - SYNC - l - 1;
      q.push_back(mk(c));
    end
  endfunction

  task automatic tick();
    @(posedge f_clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b1; f_clk_locked = 1'b1; sys_reset = 1'b0;
    sw_reset_req = '0; cause_clr = 1'b0;
    #2 resetn = 1'b0;
    #1;
    n_tests++;
    if (domain_resetn !== 3'b000 || seq_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_outs: dom=%b busy=%b, expected 000 1",
               domain_resetn, seq_busy);
    end
    n_tests++;
    if (reset_cause !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_cause: got %b, expected 0001", reset_cause);
    end
    tick(); tick();
    n_tests++;
    if (domain_resetn !== 3'b000 || seq_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_held: dom=%b busy=%b, expected 000 1",
               domain_resetn, seq_busy);
    end
  endtask

  task automatic test_por();
    exp_t e;
    resetn = 1'b1;
    push_seq(-1000, 0, TOTAL + SYNC + 4);
    for (int n = 1; q.size() > 0; n++) begin
      tick();
      e = q.pop_front();
      n_tests++;
      if (domain_resetn !== e.dom || seq_busy !== e.busy) begin
        n_fail++;
        $display("FAIL por edge %0d: dom=%b busy=%b, expected %b %b",
                 n, domain_resetn, seq_busy, e.dom, e.busy);
      end
    end
    n_tests++;
    if (reset_cause !== 4'b0001) begin
      n_fail++;
      $display("FAIL por_cause: got %b, expected 0001", reset_cause);
    end
  endtask

  task automatic test_ext_reset();
    exp_t e;
    push_seq(TOTAL, 1, SYNC + 2 + TOTAL + 2);
    for (int n = 1; q.size() > 0; n++) begin
      sys_reset = (n == 1);
      tick();
      e = q.pop_front();
      n_tests++;
      if (domain_resetn !== e.dom || seq_busy !== e.busy) begin
        n_fail++;
        $display("FAIL ext edge %0d: dom=%b busy=%b, expected %b %b",
                 n, domain_resetn, seq_busy, e.dom, e.busy);
      end
    end
    sys_reset = 1'b0;
    n_tests++;
    if (reset_cause !== 4'b0011) begin
      n_fail++;
      $display("FAIL ext_cause: got %b, expected 0011", reset_cause);
    end
  endtask

  task automatic test_lock_loss();
    exp_t e;
    push_seq(TOTAL, 3, SYNC + 3 + 40);
    for (int n = 1; q.size() > 0; n++) begin
      f_clk_locked = !(n >= 1 && n <= 3);
      tick();
      e = q.pop_front();
      n_tests++;
      if (domain_resetn !== e.dom || seq_busy !== e.busy) begin
        n_fail++;
        $display("FAIL lock edge %0d: dom=%b busy=%b, expected %b %b",
                 n, domain_resetn, seq_busy, e.dom, e.busy);
      end
    end
    n_tests++;
    if (reset_cause !== 4'b0111) begin
      n_fail++;
      $display("FAIL lock_cause: got %b, expected 0111", reset_cause);
    end
    push_seq(40, 1, SYNC + 2 + TOTAL + 2);
    for (int n = 1; q.size() > 0; n++) begin
      f_clk_locked = (n != 1);
      tick();
      e = q.pop_front();
      n_tests++;
      if (domain_resetn !== e.dom || seq_busy !== e.busy) begin
        n_fail++;
        $display("FAIL lock_mid edge %0d: dom=%b busy=%b, exp %b %b",
                 n, domain_resetn, seq_busy, e.dom, e.busy);
      end
    end
    f_clk_locked = 1'b1;
  endtask

  task automatic test_sw_reset();
    exp_t e;
    int   r1;
    int   r0;
    r1 = thr(1) - SWH;
    r0 = thr(0) - SWH;
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    n_tests++;
    if (reset_cause !== 4'b0000) begin
      n_fail++;
      $display("FAIL sw_pre_clr: got %b, expected 0000", reset_cause);
    end
    q.push_back(exp_t'{3'b001, 1'b1});
    for (int n = 2; n <= TOTAL + 4 - r1; n++) q.push_back(mk(r1 + n - 2));
    for (int n = 1; q.size() > 0; n++) begin
      sw_reset_req = (n == 1) ? 3'b010 : (n == 4) ? 3'b100 : 3'b000;
      tick();
      e = q.pop_front();
      n_tests++;
      if (domain_resetn !== e.dom || seq_busy !== e.busy) begin
        n_fail++;
        $display("FAIL sw edge %0d: dom=%b busy=%b, expected %b %b",
                 n, domain_resetn, seq_busy, e.dom, e.busy);
      end
    end
    n_tests++;
    if (reset_cause !== 4'b1000) begin
      n_fail++;
      $display("FAIL sw_cause: got %b, expected 1000", reset_cause);
    end
    q.push_back(exp_t'{3'b001, 1'b1});
    for (int n = 2; n <= 5; n++) q.push_back(mk(r1 + n - 2));
    q.push_back(exp_t'{3'b000, 1'b1});
    for (int n = 7; n <= TOTAL + 9 - r0; n++) q.push_back(mk(r0 + n - 7));
    for (int n = 1; q.size() > 0; n++) begin
      sw_reset_req = (n == 1) ? 3'b010 : (n == 6) ? 3'b001 : 3'b000;
      tick();
      e = q.pop_front();
      n_tests++;
      if (domain_resetn !== e.dom || seq_busy !== e.busy) begin
        n_fail++;
        $display("FAIL sw_nest edge %0d: dom=%b busy=%b, exp %b %b",
                 n, domain_resetn, seq_busy, e.dom, e.busy);
      end
    end
    sw_reset_req = '0;
  endtask

  task automatic test_hold_priority();
    exp_t e;
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    n_tests++;
    if (reset_cause !== 4'b0000) begin
      n_fail++;
      $display("FAIL lone_clr: got %b, expected 0000", reset_cause);
    end
    push_seq(TOTAL, 1, SYNC + 2 + TOTAL + 2);
    for (int n = 1; q.size() > 0; n++) begin
      sys_reset    = (n == 1);
      sw_reset_req = (n == SYNC + 1) ? 3'b110 : 3'b000;
      tick();
      e = q.pop_front();
      n_tests++;
      if (domain_resetn !== e.dom || seq_busy !== e.busy) begin
        n_fail++;
        $display("FAIL prio edge %0d: dom=%b busy=%b, expected %b %b",
                 n, domain_resetn, seq_busy, e.dom, e.busy);
      end
    end
    sys_reset = 1'b0;
    sw_reset_req = '0;
    n_tests++;
    if (reset_cause !== 4'b0010) begin
      n_fail++;
      $display("FAIL prio_cause: got %b, expected 0010", reset_cause);
    end
  endtask

  task automatic test_cause_clr();
    exp_t e;
    push_seq(TOTAL, 1, SYNC + 2 + TOTAL + 2);
    for (int n = 1; q.size() > 0; n++) begin
      f_clk_locked = (n != 1);
      cause_clr    = (n == SYNC + 1);
      tick();
      e = q.pop_front();
      n_tests++;
      if (domain_resetn !== e.dom || seq_busy !== e.busy) begin
        n_fail++;
        $display("FAIL clr edge %0d: dom=%b busy=%b, expected %b %b",
                 n, domain_resetn, seq_busy, e.dom, e.busy);
      end
      if (n == SYNC + 1) begin
        n_tests++;
        if (reset_cause !== 4'b0100) begin
          n_fail++;
          $display("FAIL clr_vs_set: got %b, expected 0100",
                   reset_cause);
        end
      end
    end
    f_clk_locked = 1'b1;
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    n_tests++;
    if (reset_cause !== 4'b0000) begin
      n_fail++;
      $display("FAIL clr_lone: got %b, expected 0000", reset_cause);
    end
  endtask

  task automatic test_async_reset();
    #2 resetn = 1'b0;
    #1;
    n_tests++;
    if (domain_resetn !== 3'b000 || seq_busy !== 1'b1 ||
        reset_cause !== 4'b0001) begin
      n_fail++;
      $display("FAIL async_rst: dom=%b busy=%b cause=%b, exp 000 1 0001",
               domain_resetn, seq_busy, reset_cause);
    end
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_por();
    test_ext_reset();
    test_lock_loss();
    test_sw_reset();
    test_hold_priority();
    test_cause_clr();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
